// File: rtl/alu_op_sequencer_pkg.sv
// Shared types for the ALU op sequencer: FSM states, instruction classes, operand routing
// and the function-control bit map driven to the ALU.
package alu_op_sequencer_pkg;

  typedef enum logic [1:0] {StIdle, StFetch, StExec, StWb} state_e;

  typedef enum logic [2:0] {
    ClsNone, ClsMain, ClsInc, ClsLogic, ClsRotA, ClsMisc, ClsBit, ClsResSet
  } alu_class_e;

  typedef enum logic [2:0] {SrcNone, SrcReg, SrcA, SrcHl, SrcImm} src_e;
  typedef enum logic [1:0] {DstNone, DstReg, DstA, DstMem} dst_e;

  typedef struct packed {
    alu_class_e cls;
    src_e       src;
    dst_e       dst;
    logic [2:0] reg_idx;
    logic       wb_en;
    logic       flags_en;
  } dec_t;

  localparam dec_t DecNop = '{
    cls: ClsNone, src: SrcNone, dst: DstNone, reg_idx: 3'd0, wb_en: 1'b0, flags_en: 1'b0
  };

  localparam int unsigned FcMain  = 0;
  localparam int unsigned FcInc   = 1;
  localparam int unsigned FcDec   = 2;
  localparam int unsigned FcLogic = 3;
  localparam int unsigned FcNoZ   = 4;
  localparam int unsigned FcMisc  = 5;

  localparam logic [2:0] RegHl = 3'd6;
  localparam logic [2:0] RegA  = 3'd7;

  function automatic src_e src_of(logic [2:0] r);
    if (r == RegHl) return SrcHl;
    if (r == RegA) return SrcA;
    return SrcReg;
  endfunction

  function automatic dst_e dst_of(logic [2:0] r);
    if (r == RegHl) return DstMem;
    if (r == RegA) return DstA;
    return DstReg;
  endfunction

  function automatic logic [5:0] fc_of(alu_class_e cls, logic is_dec);
    logic [5:0] fc;
    fc = '0;
    case (cls)
      ClsMain: fc[FcMain] = 1'b1;
      ClsInc: begin
        fc[FcInc] = 1'b1;
        fc[FcDec] = is_dec;
      end
      ClsLogic, ClsBit, ClsResSet: fc[FcLogic] = 1'b1;
      ClsRotA: begin
        fc[FcLogic] = 1'b1;
        fc[FcNoZ]   = 1'b1;
      end
      ClsMisc: fc[FcMisc] = 1'b1;
      default: ;
    endcase
    return fc;
  endfunction

endpackage

// File: rtl/alu_op_sequencer_decoder.sv
// Combinational decode of {CB prefix, opcode} into class, operand source, destination
// and write-back / flag-commit enables. Unrecognised opcodes decode to DecNop.
module alu_op_sequencer_decoder
  import alu_op_sequencer_pkg::*;
(
  input  logic       cb_prefix,
  input  logic [7:0] opcode,
  output dec_t       dec
);

  logic [2:0] r_lo;
  logic [2:0] r_hi;

  assign r_lo = opcode[2:0];
  assign r_hi = opcode[5:3];

  always_comb begin
    dec = DecNop;
    if (cb_prefix) begin
      dec.src      = src_of(r_lo);
      dec.reg_idx  = r_lo;
      dec.flags_en = 1'b1;
      unique case (opcode[7:6])
        2'b00: begin
          dec.cls = ClsLogic;
          dec.dst = dst_of(r_lo);
        end
        2'b01: dec.cls = ClsBit;
        default: begin
          dec.cls      = ClsResSet;
          dec.dst      = dst_of(r_lo);
          dec.flags_en = 1'b0;
        end
      endcase
    end else if (opcode[7:6] == 2'b10 || (opcode[7:6] == 2'b11 && r_lo == 3'd6)) begin
      // 80-BF register/(HL) forms and the C6..FE immediate forms; CP (111) only sets flags
      dec.cls      = ClsMain;
      dec.src      = opcode[6] ? SrcImm : src_of(r_lo);
      dec.reg_idx  = r_lo;
      dec.flags_en = 1'b1;
      if (r_hi != 3'd7) dec.dst = DstA;
    end else if (opcode[7:6] == 2'b00 && opcode[2:1] == 2'b10) begin
      dec.cls      = ClsInc;
      dec.src      = src_of(r_hi);
      dec.dst      = dst_of(r_hi);
      dec.reg_idx  = r_hi;
      dec.flags_en = 1'b1;
    end else if (opcode[7:6] == 2'b00 && r_lo == 3'd7) begin
      dec.src      = SrcA;
      dec.flags_en = 1'b1;
      if (!opcode[5]) begin
        dec.cls = ClsRotA;
        dec.dst = DstA;
      end else begin
        // DAA/CPL write A; SCF/CCF only touch flags
        dec.cls = ClsMisc;
        if (!opcode[4]) dec.dst = DstA;
      end
    end
    dec.wb_en = (dec.dst != DstNone);
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Multi-cycle sequencer for one 8-bit ALU-class instruction: FETCH operand, EXEC on the ALU,
// optional WB. Define ALU_SEQ_ILLEGAL_TRAP_EN to add the o_Illegal trap output.
module alu_op_sequencer (
  input  logic       i_Clk,
  input  logic       i_Reset,
  input  logic       i_Enable,
  input  logic       i_Start,
  input  logic [7:0] i_Opcode,
  input  logic       i_CB_Prefix,
  output logic       o_Busy,
  output logic       o_Done,
  output logic [2:0] o_Reg_Sel,
  input  logic [7:0] i_Reg_Data,
  output logic       o_Reg_Write,
  input  logic [7:0] i_A_Data,
  output logic       o_Mem_Req,
  output logic       o_Mem_Write,
  output logic       o_Mem_Addr_Sel,
  input  logic       i_Mem_Ready,
  input  logic [7:0] i_Mem_Data,
  output logic [7:0] o_ALU_Opcode,
  output logic [7:0] o_ALU_Parameter,
  output logic [5:0] o_ALU_Function_Control,
  output logic       o_ALU_Save_Flags,
  output logic [1:0] o_ALU_Write,
  input  logic [7:0] i_ALU_Result,
  output logic [7:0] o_Wr_Data
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
  ,
  output logic       o_Illegal
`endif
);
  import alu_op_sequencer_pkg::*;

  state_e     state_q, state_d;
  dec_t       dec_q, dec_d, dec_new;
  logic [7:0] op_q, op_d;
  logic [7:0] param_q, param_d;
  logic [7:0] wr_q, wr_d;

  alu_op_sequencer_decoder u_decoder (
    .cb_prefix (i_CB_Prefix),
    .opcode    (i_Opcode),
    .dec       (dec_new)
  );

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      state_q <= StIdle;
      dec_q   <= DecNop;
      op_q    <= '0;
      param_q <= '0;
      wr_q    <= '0;
    end else if (i_Enable) begin
      state_q <= state_d;
      dec_q   <= dec_d;
      op_q    <= op_d;
      param_q <= param_d;
      wr_q    <= wr_d;
    end
  end

  always_comb begin
    state_d                = state_q;
    dec_d                  = dec_q;
    op_d                   = op_q;
    param_d                = param_q;
    wr_d                   = wr_q;
    o_Busy                 = (state_q != StIdle);
    o_Done                 = 1'b0;
    o_Reg_Sel              = 3'd0;
    o_Reg_Write            = 1'b0;
    o_Mem_Req              = 1'b0;
    o_Mem_Write            = 1'b0;
    o_Mem_Addr_Sel         = 1'b0;
    o_ALU_Function_Control = 6'd0;
    o_ALU_Save_Flags       = 1'b0;
    o_ALU_Write            = 2'b00;

    unique case (state_q)
      StIdle: begin
        if (i_Start) begin
          op_d    = i_Opcode;
          dec_d   = dec_new;
          state_d = StFetch;
        end
      end
      StFetch: begin
        unique case (dec_q.src)
          SrcReg: begin
            o_Reg_Sel = dec_q.reg_idx;
            param_d   = i_Reg_Data;
            state_d   = StExec;
          end
          SrcA: begin
            param_d = i_A_Data;
            state_d = StExec;
          end
          SrcHl, SrcImm: begin
            o_Mem_Req      = 1'b1;
            o_Mem_Addr_Sel = (dec_q.src == SrcHl);
            if (i_Mem_Ready) begin
              param_d = i_Mem_Data;
              state_d = StExec;
            end
          end
          default: begin
            // Non-ALU opcode: finish here without touching the ALU or any destination
            o_Done  = 1'b1;
            state_d = StIdle;
          end
        endcase
      end
      StExec: begin
        o_ALU_Function_Control = fc_of(dec_q.cls, op_q[0]);
        o_ALU_Save_Flags       = dec_q.flags_en;
        wr_d                   = i_ALU_Result;
        if (dec_q.wb_en) begin
          state_d = StWb;
        end else begin
          o_Done  = 1'b1;
          state_d = StIdle;
        end
      end
      StWb: begin
        unique case (dec_q.dst)
          DstA: begin
            o_ALU_Write = 2'b01;
            o_Done      = 1'b1;
            state_d     = StIdle;
          end
          DstReg: begin
            o_Reg_Sel   = dec_q.reg_idx;
            o_Reg_Write = 1'b1;
            o_Done      = 1'b1;
            state_d     = StIdle;
          end
          DstMem: begin
            o_Mem_Req      = 1'b1;
            o_Mem_Write    = 1'b1;
            o_Mem_Addr_Sel = 1'b1;
            if (i_Mem_Ready) begin
              o_Done  = 1'b1;
              state_d = StIdle;
            end
          end
          default: begin
            o_Done  = 1'b1;
            state_d = StIdle;
          end
        endcase
      end
      default: state_d = StIdle;
    endcase
  end

  assign o_ALU_Opcode    = op_q;
  assign o_ALU_Parameter = param_q;
  assign o_Wr_Data       = wr_q;

`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
  assign o_Illegal = (state_q == StFetch) && (dec_q.src == SrcNone);
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: directed scenarios plus random opcodes against a behavioural
// model of instruction classes, operand routing, write-back and cycle latency.
module tb_alu_op_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b1;
  logic       start = 1'b0;
  logic       cb = 1'b0;
  logic [7:0] opc = 8'h00;
  logic       ready = 1'b0;
  logic [7:0] a_val = 8'h00;
  logic [7:0] mem_val = 8'h00;
  logic [7:0] regs [0:7];

  logic       busy, done, reg_write, mem_req, mem_write, addr_sel, save_flags, illegal;
  logic [2:0] reg_sel;
  logic [7:0] alu_opc, alu_param, wr_data, alu_res, reg_data;
  logic [5:0] fc;
  logic [1:0] alu_write;
  logic [41:0] outs;

  int checks = 0;
  int errors = 0;
  logic [8:0] cur_op = '0;

  always #5 clk = ~clk;

  function automatic logic [7:0] alu_fn(logic [5:0] f, logic [7:0] op, logic [7:0] p,
                                        logic [7:0] a);
    if (f == 6'b000001 && op[5:3] == 3'd0) return a + p;
    if (f[1]) return f[2] ? p - 8'd1 : p + 8'd1;
    return p ^ 8'hA5;
  endfunction

  assign reg_data = regs[reg_sel];
  assign alu_res  = alu_fn(fc, alu_opc, alu_param, a_val);
  assign outs = {busy, done, reg_sel, reg_write, mem_req, mem_write, addr_sel, alu_opc,
                 alu_param, fc, save_flags, alu_write, wr_data};

`ifndef ALU_SEQ_ILLEGAL_TRAP_EN
  assign illegal = 1'b0;
`endif

  alu_op_sequencer dut (
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
    .o_Illegal              (illegal),
`endif
    .i_Clk                  (clk),
    .i_Reset                (rst),
    .i_Enable               (en),
    .i_Start                (start),
    .i_Opcode               (opc),
    .i_CB_Prefix            (cb),
    .o_Busy                 (busy),
    .o_Done                 (done),
    .o_Reg_Sel              (reg_sel),
    .i_Reg_Data             (reg_data),
    .o_Reg_Write            (reg_write),
    .i_A_Data               (a_val),
    .o_Mem_Req              (mem_req),
    .o_Mem_Write            (mem_write),
    .o_Mem_Addr_Sel         (addr_sel),
    .i_Mem_Ready            (ready),
    .i_Mem_Data             (mem_val),
    .o_ALU_Opcode           (alu_opc),
    .o_ALU_Parameter        (alu_param),
    .o_ALU_Function_Control (fc),
    .o_ALU_Save_Flags       (save_flags),
    .o_ALU_Write            (alu_write),
    .i_ALU_Result           (alu_res),
    .o_Wr_Data              (wr_data)
  );

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s (cb %0d op %02h): observed %0h expected %0h", name, cur_op[8], cur_op[7:0],
             obs, exp);
    end
  endtask

  // Operand kinds: 0 reg, 1 A, 2 (HL), 3 imm. Destination kinds: 0 none, 1 reg, 2 A, 3 (HL).
  function automatic int src_kind(int r);
    return (r == 6) ? 2 : (r == 7) ? 1 : 0;
  endfunction

  function automatic int dst_kind(int r);
    return (r == 6) ? 3 : (r == 7) ? 2 : 1;
  endfunction

  task automatic model(input logic c, input logic [7:0] op, output bit legal, output int srck,
                       output int r, output int dstk, output logic [5:0] efc, output bit flg);
    int lo;
    int hi;
    lo = int'(op) % 8;
    hi = (int'(op) / 8) % 8;
    legal = 1'b1; srck = src_kind(lo); r = lo; dstk = 0; efc = 6'd0; flg = 1'b1;
    if (c) begin
      efc = 6'b001000;
      if (op < 8'h40) dstk = dst_kind(lo);
      else if (op >= 8'h80) begin dstk = dst_kind(lo); flg = 1'b0; end
    end else if (op >= 8'h80 && op <= 8'hBF) begin
      efc = 6'b000001;
      if (hi != 7) dstk = 2;
    end else if (op >= 8'hC0 && lo == 6) begin
      efc = 6'b000001; srck = 3;
      if (op != 8'hFE) dstk = 2;
    end else if (op < 8'h40 && (lo == 4 || lo == 5)) begin
      r = hi; srck = src_kind(hi); dstk = dst_kind(hi);
      efc = (lo == 4) ? 6'b000010 : 6'b000110;
    end else if (op == 8'h07 || op == 8'h0F || op == 8'h17 || op == 8'h1F) begin
      srck = 1; dstk = 2; efc = 6'b011000;
    end else if (op == 8'h27 || op == 8'h2F || op == 8'h37 || op == 8'h3F) begin
      srck = 1; efc = 6'b100000;
      if (op == 8'h27 || op == 8'h2F) dstk = 2;
    end else begin
      legal = 1'b0;
    end
  endtask

  task automatic set_regs(input logic [7:0] base, input logic [7:0] a, input logic [7:0] m);
    for (int i = 0; i < 8; i++) regs[i] = base + 8'(i * 8'h11);
    a_val = a;
    mem_val = m;
  endtask

  task automatic run_op(input logic c, input logic [7:0] op, input int waits, input int freeze);
    bit legal, flg, fin;
    int srck, r, dstk, cyc, wcnt, exp_done, done_cyc;
    int fc_cnt, sf_cnt, aw_cnt, rw_cnt, mw_cnt, mr_cnt, busy_low, il_cnt;
    logic [5:0] efc, fc_seen;
    logic [1:0] aw_val;
    logic [2:0] rw_idx;
    logic [7:0] aw_data, rw_data, mw_data, operand, res;
    logic mw_sel, mr_sel;
    logic [41:0] snap;
    fin = 0; cyc = 0; wcnt = 0; done_cyc = 0; fc_cnt = 0; sf_cnt = 0; aw_cnt = 0; rw_cnt = 0;
    mw_cnt = 0; mr_cnt = 0; busy_low = 0; il_cnt = 0; fc_seen = '0; aw_val = '0; rw_idx = '0;
    aw_data = '0; rw_data = '0; mw_data = '0; mw_sel = 0; mr_sel = 0;
    model(c, op, legal, srck, r, dstk, efc, flg);
    operand = (srck == 0) ? regs[r] : (srck == 1) ? a_val : mem_val;
    res = alu_fn(efc, op, operand, a_val);
    exp_done = !legal ? 1 : ((srck >= 2) ? waits + 1 : 1) + 1 +
               ((dstk == 0) ? 0 : (dstk == 3) ? waits + 1 : 1);
    cur_op = {c, op};
    @(negedge clk);
    start = 1'b1; cb = c; opc = op;
    @(posedge clk);
    #1 start = 1'b0; opc = 8'($urandom);
    while (!fin && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (mem_req) begin
        ready = (wcnt == waits);
        wcnt = ready ? 0 : wcnt + 1;
      end else begin
        ready = 1'($urandom);  // stray ready outside a memory phase must be ignored
        wcnt = 0;
      end
      #1;
      if (cyc == freeze) begin
        snap = outs; en = 1'b0; start = 1'b1; opc = ~op;
        repeat (3) begin
          @(negedge clk);
          #1 check("freeze_hold", outs, snap);
        end
        start = 1'b0; en = 1'b1;
      end
      if (!busy) busy_low++;
      if (fc != 6'd0) begin fc_cnt++; fc_seen = fc; end
      if (save_flags) sf_cnt++;
      if (alu_write != 2'b00) begin aw_cnt++; aw_val = alu_write; aw_data = wr_data; end
      if (reg_write) begin rw_cnt++; rw_idx = reg_sel; rw_data = wr_data; end
      if (mem_req && ready && mem_write) begin mw_cnt++; mw_data = wr_data; mw_sel = addr_sel; end
      if (mem_req && ready && !mem_write) begin mr_cnt++; mr_sel = addr_sel; end
      if (illegal) il_cnt++;
      if (done) begin done_cyc = cyc; fin = 1; end
    end
    check("done_cycle", done_cyc, exp_done);
    check("busy_low", busy_low, 0);
    check("fc_count", fc_cnt, legal);
    if (legal) check("fc_value", fc_seen, efc);
    check("save_flags_count", sf_cnt, legal && flg);
    check("alu_write_count", aw_cnt, dstk == 2);
    if (dstk == 2) check("alu_write", {aw_val, aw_data}, {2'b01, res});
    check("reg_write_count", rw_cnt, dstk == 1);
    if (dstk == 1) check("reg_write", {rw_idx, rw_data}, {3'(r), res});
    check("mem_write_count", mw_cnt, dstk == 3);
    if (dstk == 3) check("mem_write", {mw_sel, mw_data}, {1'b1, res});
    check("mem_read_count", mr_cnt, legal && srck >= 2);
    if (legal && srck >= 2) check("mem_read_sel", mr_sel, srck == 2);
    if (legal) check("operand", alu_param, operand);
    if (legal) check("alu_opcode", alu_opc, op);
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
    check("illegal_count", il_cnt, !legal);
`endif
    @(negedge clk);
    ready = 1'b0;
    #1 check("idle_after_done", {busy, done}, 2'b00);
  endtask

  initial begin
    int quiet;
    set_regs(8'h3A, 8'h0F, 8'h00);
    #1 check("reset_outputs", outs, 42'd0);
    @(negedge clk);
    rst = 1'b0;
    #1 check("idle_not_busy", busy, 1'b0);

    // ADD A,B with B=3A, A=0F
    run_op(1'b0, 8'h80, 0, -1);
    check("add_result", wr_data, 8'h49);
    // CP d8, two memory waits
    set_regs(8'h10, 8'h20, 8'h20);
    run_op(1'b0, 8'hFE, 2, -1);
    // INC (HL) with (HL)=FF
    set_regs(8'h05, 8'h44, 8'hFF);
    run_op(1'b0, 8'h34, 1, -1);
    check("inc_hl_result", wr_data, 8'h00);
    // BIT 7,(HL) and SET 0,(HL)
    run_op(1'b1, 8'h7E, 0, -1);
    run_op(1'b1, 8'hC6, 1, -1);
    // DEC E, RRA, SCF, CPL, non-ALU opcode
    set_regs(8'h61, 8'h9C, 8'h3C);
    run_op(1'b0, 8'h1D, 0, -1);
    run_op(1'b0, 8'h1F, 0, -1);
    run_op(1'b0, 8'h37, 0, -1);
    run_op(1'b0, 8'h2F, 0, -1);
    run_op(1'b0, 8'h00, 0, -1);
    // Enable held low for 3 cycles in EXEC, with start pulses while busy
    set_regs(8'h3A, 8'h0F, 8'h00);
    run_op(1'b0, 8'h80, 0, 2);

    // Reset during WB of ADD A,B
    cur_op = 9'h080;
    @(negedge clk);
    start = 1'b1; cb = 1'b0; opc = 8'h80;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(negedge clk);
    #1 check("wb_reached", alu_write, 2'b01);
    rst = 1'b1;
    #1 check("reset_mid_wb", outs, 42'd0);
    @(negedge clk);
    rst = 1'b0;
    quiet = 0;
    repeat (3) begin
      @(negedge clk);
      #1 if (busy || done || alu_write != 2'b00) quiet++;
    end
    check("post_reset_quiet", quiet, 0);
    run_op(1'b0, 8'h80, 0, -1);

    for (int i = 0; i < 40; i++) begin
      set_regs(8'($urandom), 8'($urandom), 8'($urandom));
      run_op(1'($urandom), 8'($urandom), int'($urandom_range(0, 3)), -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
